// File: rtl/ext_arbiter.sv
// Four-requester round-robin arbiter feeding one registered immediate-extension unit; one grant per cycle, result one cycle later.
// Define EXT_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (requester 0 highest).
module ext_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req_valid,
  input  logic [63:0] req_imm,
  input  logic [7:0]  req_eop,
  output logic [3:0]  req_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_ext,
  output logic [1:0]  out_id,
  output logic [15:0] xfer_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [31:0] ext_q, ext_d;
  logic [1:0]  id_q, id_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  gnt;
  logic        acc;

  function automatic logic [31:0] extend(input logic [15:0] imm, input logic [1:0] eop);
    case (eop)
      2'b00:   extend = {{16{imm[15]}}, imm};
      2'b01:   extend = {16'h0000, imm};
      2'b10:   extend = {imm, 16'h0000};
      default: extend = {{14{imm[15]}}, imm, 2'b00};
    endcase
  endfunction

`ifdef EXT_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req_valid[i]) gnt = 2'(i);
    end
  end
`else
  logic [1:0] ptr_q, ptr_d;

  // Scan offsets high to low so the valid requester nearest ptr wins.
  always_comb begin
    gnt = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (req_valid[ptr_q + 2'(k)]) gnt = ptr_q + 2'(k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 2'd0;
    else        ptr_q <= ptr_d;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (acc) ptr_d = gnt + 2'd1;
  end
`endif

  assign out_valid = (state_q == FULL);
  // rst_n gates acceptance so no requester sees a strobe while reset is held.
  assign acc       = (|req_valid) & (~out_valid | out_ready) & rst_n;

  always_comb begin
    state_d   = state_q;
    ext_d     = ext_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    req_ready = 4'b0000;
    if (out_valid && out_ready) cnt_d = cnt_q + 16'd1;
    case (state_q)
      EMPTY:   if (acc) state_d = FULL;
      FULL:    if (!acc && out_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (acc) begin
      req_ready[gnt] = 1'b1;
      ext_d          = extend(req_imm[{gnt, 4'b0000} +: 16], req_eop[{gnt, 1'b0} +: 2]);
      id_d           = gnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ext_q   <= 32'h0;
      id_q    <= 2'd0;
      cnt_q   <= 16'h0;
    end else begin
      state_q <= state_d;
      ext_q   <= ext_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_ext  = ext_q;
  assign out_id   = id_q;
  assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_ext_arbiter.sv
// Directed and randomized bench for ext_arbiter against a queue-free arithmetic reference model.
// Honors EXT_ARB_FIXED_PRIO_EN so the same bench checks either grant policy.
module tb_ext_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = 4'b1111;
  logic [63:0] req_imm = 64'h0;
  logic [7:0]  req_eop = 8'h0;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_ext;
  logic [1:0]  out_id;
  logic [15:0] xfer_cnt;

  ext_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_imm(req_imm), .req_eop(req_eop),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_ext(out_ext), .out_id(out_id), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail = 0;
  int          m_ptr = 0;
  logic        m_valid = 1'b0;
  logic [31:0] m_ext = 32'h0;
  int          m_id = 0;
  logic [15:0] m_cnt = 16'h0;
  int          last_g = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] eop);
    int s;
    s = int'($signed(imm));
    case (eop)
      2'd0:    return 32'(s);
      2'd1:    return 32'(imm);
      2'd2:    return 32'(imm) * 32'd65536;
      default: return 32'(s * 4);
    endcase
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 1'b0; m_ext = 32'h0; m_id = 0; m_cnt = 16'h0;
  endtask

  task automatic set_req(input int i, input logic [15:0] imm, input logic [1:0] eop);
    req_imm[16*i +: 16] = imm;
    req_eop[2*i +: 2]   = eop;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cyc(input string tag);
    int g, start, idx;
    logic acc;
    logic [3:0] exp_rdy;
    g = -1;
`ifdef EXT_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = m_ptr;
`endif
    for (int k = 0; k < 4; k++) begin
      idx = (start + k) % 4;
      if (g < 0 && req_valid[idx]) g = idx;
    end
    acc = (g >= 0) && (!m_valid || out_ready);
    exp_rdy = acc ? 4'(1 << g) : 4'b0000;
    #1 chk({tag, ".req_ready"}, 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    if (m_valid && out_ready) m_cnt = m_cnt + 16'd1;
    if (acc) begin
      m_ext   = ref_ext(req_imm[16*g +: 16], req_eop[2*g +: 2]);
      m_id    = g;
      m_valid = 1'b1;
      m_ptr   = (g + 1) % 4;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    last_g = acc ? g : -1;
    #1;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".xfer_cnt"}, 32'(xfer_cnt), 32'(m_cnt));
    if (m_valid) begin
      chk({tag, ".out_ext"}, out_ext, m_ext);
      chk({tag, ".out_id"}, 32'(out_id), 32'(m_id));
    end
    @(negedge clk);
  endtask

  logic [31:0] sweep_tbl [4] = '{32'hFFFF8004, 32'h00008004, 32'h80040000, 32'hFFFE0010};
  int          grant_tbl [5];
  logic [15:0] cnt_hold;
  logic        pv [4];
  logic [15:0] pimm [4];
  logic [1:0]  peop [4];
  int          guard;

  initial begin
`ifdef EXT_ARB_FIXED_PRIO_EN
    grant_tbl = '{0, 0, 0, 0, 0};
`else
    grant_tbl = '{0, 1, 2, 3, 0};
`endif
    #1;
    chk("rst.req_ready", 32'(req_ready), 32'h0);
    chk("rst.out_valid", 32'(out_valid), 32'h0);
    chk("rst.out_ext", out_ext, 32'h0);
    chk("rst.out_id", 32'(out_id), 32'h0);
    chk("rst.xfer_cnt", 32'(xfer_cnt), 32'h0);

    // First request right after reset release
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 4'b0001; set_req(0, 16'h8001, 2'b00); out_ready = 1'b1;
    cyc("first");
    chk("first.ext", out_ext, 32'hFFFF8001);
    chk("first.id", 32'(out_id), 32'h0);
    req_valid = 4'b0000;
    cyc("first_drain");
    chk("first.cnt", 32'(xfer_cnt), 32'h1);

    // Extension-op sweep through requester 3, leaving the pointer at 0
    req_valid = 4'b1000;
    for (int e = 0; e < 4; e++) begin
      set_req(3, 16'h8004, 2'(e));
      cyc("sweep");
      chk($sformatf("sweep.eop%0d", e), out_ext, sweep_tbl[e]);
    end

    // All requesters held valid: grant order and back-to-back results
    set_req(0, 16'h0010, 2'b01); set_req(1, 16'h0011, 2'b01);
    set_req(2, 16'h0012, 2'b01); set_req(3, 16'h0013, 2'b01);
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      cyc("rr");
      chk($sformatf("rr.grant%0d", i), 32'(out_id), 32'(grant_tbl[i]));
      chk($sformatf("rr.ext%0d", i), out_ext, 32'h10 + 32'(grant_tbl[i]));
    end

    // Downstream stall with 0x00001234 held
    req_valid = 4'b0100; set_req(2, 16'h1234, 2'b01);
    cyc("stall_load");
    out_ready = 1'b0; req_valid = 4'b1111;
    cnt_hold = xfer_cnt;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall.req_ready", 32'(req_ready), 32'h0);
      cyc("stall");
      chk("stall.ext", out_ext, 32'h00001234);
      chk("stall.cnt", 32'(xfer_cnt), 32'(cnt_hold));
    end
    out_ready = 1'b1;
    cyc("unstall");
    chk("unstall.cnt", 32'(xfer_cnt), 32'(cnt_hold + 16'd1));
    chk("unstall.valid", 32'(out_valid), 32'h1);

    // Randomized traffic with requesters holding until granted
    for (int i = 0; i < 4; i++) pv[i] = 1'b0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pv[i] && $urandom_range(0, 2) == 0) begin
          pv[i] = 1'b1; pimm[i] = 16'($urandom); peop[i] = 2'($urandom);
        end
        req_valid[i] = pv[i];
        set_req(i, pimm[i], peop[i]);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cyc("rand");
      if (last_g >= 0) pv[last_g] = 1'b0;
    end

    // Saturate transfers up to 0xFFFF, then wrap
    req_valid = 4'b1111; out_ready = 1'b1;
    guard = 0;
    while (m_cnt != 16'hFFFF && guard < 70000) begin
      cyc("bulk");
      guard++;
    end
    chk("bulk.cnt_max", 32'(xfer_cnt), 32'h0000FFFF);
    chk("bulk.valid", 32'(out_valid), 32'h1);
    cyc("wrap");
    chk("wrap.cnt", 32'(xfer_cnt), 32'h0);
    cyc("post_wrap");
    cyc("post_wrap");

    // Asynchronous reset while a result is held
    out_ready = 1'b0;
    cyc("hold");
    #2 rst_n = 1'b0;
    #1;
    chk("arst.out_valid", 32'(out_valid), 32'h0);
    chk("arst.xfer_cnt", 32'(xfer_cnt), 32'h0);
    chk("arst.out_ext", out_ext, 32'h0);
    chk("arst.out_id", 32'(out_id), 32'h0);
    chk("arst.req_ready", 32'(req_ready), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    cyc("post_rst");
    chk("post_rst.id", 32'(out_id), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
